// File: rtl/player_bullet.sv
// player_bullet: player-shot controller driving the bullet position bus and its draw signal
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   vga_x, vga_y      current draw column/row
//   px                player cannon left x
//   fire              fire request (level or pulse)
//   hit               OR of all enemy b_hit outputs
//   bx, by            bullet x / top y, parked at all-ones when not flying
//   active            high while the bullet is flying
//   pixel             bullet covers (vga_x, vga_y)
//   score_inc         one-cycle pulse per confirmed hit
module player_bullet #(
    parameter int START_Y        = 170,
    parameter int SPEED          = 4,
    parameter int LEN            = 4,
    parameter int PLAYER_W       = 11,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vga_x,
    input  logic [8:0] vga_y,
    input  logic [9:0] px,
    input  logic       fire,
    input  logic       hit,
    output logic [9:0] bx,
    output logic [8:0] by,
    output logic       active,
    output logic       pixel,
    output logic       score_inc
);
    typedef enum logic [1:0] {IDLE, FLYING, EXPLODE} state_t;
    localparam int CW = $clog2(EXPLODE_FRAMES + 1);
    localparam logic [9:0] PARK_X = 10'h3FF;
    localparam logic [8:0] PARK_Y = 9'h1FF;
    state_t        state_q, state_d;
    logic          fire_pending_q, fire_pending_d;
    logic [9:0]    bx_q, bx_d;
    logic [8:0]    by_q, by_d;
    logic          active_q, active_d;
    logic          score_inc_q, score_inc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd;
    logic [9:0]    y_end;
    // One row after the enemy update, so the enemies' b_hit is already registered.
    assign upd = (vga_x == 10'd240) && (vga_y == 9'd181);
    always_comb begin
        state_d        = state_q;
        bx_d           = bx_q;
        by_d           = by_q;
        cnt_d          = cnt_q;
        score_inc_d    = 1'b0;
        fire_pending_d = fire_pending_q | ((state_q == IDLE) & fire);
        if (upd) begin
            case (state_q)
                IDLE: if (fire_pending_q) begin
                    bx_d           = px + 10'(PLAYER_W / 2);
                    by_d           = 9'(START_Y);
                    fire_pending_d = 1'b0;
                    state_d        = FLYING;
                end
                FLYING: if (hit) begin
                    bx_d        = PARK_X;
                    by_d        = PARK_Y;
                    score_inc_d = 1'b1;
                    cnt_d       = CW'(EXPLODE_FRAMES - 1);
                    state_d     = EXPLODE;
                end else if (by_q < 9'(SPEED)) begin
                    // Leaving the top: park instead of underflowing.
                    bx_d    = PARK_X;
                    by_d    = PARK_Y;
                    state_d = IDLE;
                end else begin
                    by_d = by_q - 9'(SPEED);
                end
                EXPLODE: begin
                    // hit is ignored here: enemy b_hit persists until the next enemy update.
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
                    state_d = (cnt_q == '0) ? IDLE : EXPLODE;
                end
                default: state_d = IDLE;
            endcase
        end
        active_d = (state_d == FLYING);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            fire_pending_q <= 1'b0;
            bx_q           <= PARK_X;
            by_q           <= PARK_Y;
            active_q       <= 1'b0;
            score_inc_q    <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            fire_pending_q <= fire_pending_d;
            bx_q           <= bx_d;
            by_q           <= by_d;
            active_q       <= active_d;
            score_inc_q    <= score_inc_d;
            cnt_q          <= cnt_d;
        end
    end
    // Bottom row computed at 10 bits so it cannot wrap.
    assign y_end     = {1'b0, by_q} + 10'(LEN - 1);
    assign pixel     = active_q & (vga_x == bx_q) & (vga_y >= by_q) & ({1'b0, vga_y} <= y_end);
    assign bx        = bx_q;
    assign by        = by_q;
    assign active    = active_q;
    assign score_inc = score_inc_q;
endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet: directed self-checking bench for player_bullet
module tb_player_bullet;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] vga_x;
    logic [8:0] vga_y;
    logic [9:0] px;
    logic       fire;
    logic       hit;
    logic [9:0] bx;
    logic [8:0] by;
    logic       active;
    logic       pixel;
    logic       score_inc;
    int errors = 0;
    int checks = 0;
    int sc_cnt = 0;
    int sc0;
    player_bullet dut (
        .clk(clk), .reset(reset), .vga_x(vga_x), .vga_y(vga_y), .px(px),
        .fire(fire), .hit(hit), .bx(bx), .by(by), .active(active),
        .pixel(pixel), .score_inc(score_inc)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (score_inc) sc_cnt <= sc_cnt + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic upd();
        vga_x = 10'd240;
        vga_y = 9'd181;
        tick();
        vga_x = 10'd0;
        vga_y = 9'd0;
    endtask
    task automatic pulse_fire();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
    endtask
    task automatic check_parked(input string tag);
        check({tag, "_bx"}, bx, 10'h3FF);
        check({tag, "_by"}, by, 9'h1FF);
        check({tag, "_active"}, active, 0);
        check({tag, "_score"}, score_inc, 0);
    endtask
    initial begin
        reset = 1'b1; fire = 1'b0; hit = 1'b0; px = 10'd0; vga_x = 10'd0; vga_y = 9'd0;
        repeat (3) tick();
        reset = 1'b0;
        check_parked("reset");
        check("reset_pixel", pixel, 0);
        sc0 = sc_cnt;
        repeat (3) upd();
        check_parked("idle3");
        check("idle3_nscore", sc_cnt - sc0, 0);
        px = 10'd100;
        tick();
        pulse_fire();
        repeat (3) tick();
        check("prefire_active", active, 0);
        upd();
        check("spawn_bx", bx, 105);
        check("spawn_by", by, 170);
        check("spawn_active", active, 1);
        upd();
        check("move1_by", by, 166);
        vga_x = 10'd105;
        for (int y = 165; y <= 170; y++) begin
            vga_y = 9'(y);
            #1;
            check($sformatf("pix_row%0d", y), pixel, (y >= 166 && y <= 169) ? 1 : 0);
        end
        vga_x = 10'd104; vga_y = 9'd167; #1;
        check("pix_col104", pixel, 0);
        vga_x = 10'd0; vga_y = 9'd0;
        for (int i = 0; i < 41; i++) begin
            if (i == 10) fire = 1'b1;
            if (i == 30) fire = 1'b0;
            upd();
        end
        check("top_by", by, 2);
        check("top_active", active, 1);
        upd();
        check_parked("miss");
        upd();
        check("noqueue_active", active, 0);
        check("miss_nscore", sc_cnt - sc0, 0);
        pulse_fire();
        check("refire_wait", active, 0);
        upd();
        check("refire_active", active, 1);
        check("refire_by", by, 170);
        repeat (5) upd();
        check("hitpos_by", by, 150);
        hit = 1'b1;
        upd();
        check("hit_score", score_inc, 1);
        check("hit_bx", bx, 10'h3FF);
        check("hit_active", active, 0);
        tick();
        check("hit_pulse1", score_inc, 0);
        upd();
        check("hit_held_score", score_inc, 0);
        hit = 1'b0;
        repeat (6) upd();
        pulse_fire();
        upd();
        check("explode_end_active", active, 0);
        upd();
        check("explode_fire_ignored", active, 0);
        check("one_score", sc_cnt - sc0, 1);
        pulse_fire();
        upd();
        check("rearm_active", active, 1);
        repeat (10) upd();
        check("fly130_by", by, 130);
        reset = 1'b1; fire = 1'b1; vga_x = 10'd240; vga_y = 9'd181;
        tick();
        reset = 1'b0; fire = 1'b0; vga_x = 10'd0; vga_y = 9'd0;
        check_parked("rst_fly");
        upd();
        check("rst_fly_after", active, 0);
        pulse_fire();
        upd();
        hit = 1'b1;
        upd();
        hit = 1'b0;
        repeat (3) upd();
        pulse_fire();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_parked("rst_expl");
        upd();
        check("rst_expl_after", active, 0);
        pulse_fire();
        upd();
        check("rst_expl_idle", active, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_fire();
        reset = 1'b1; vga_x = 10'd240; vga_y = 9'd181;
        tick();
        reset = 1'b0; vga_x = 10'd0; vga_y = 9'd0;
        upd();
        check("rst_pending_clr", active, 0);
        check("total_score", sc_cnt - sc0, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
